// File: rtl/imem_program_loader.sv
// Byte-stream to instruction-memory writer; holds the core in reset until the image is loaded.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// LEN_HI | waiting for word-count high byte
// LEN_LO | waiting for word-count low byte
// WORD   | assembling a 32-bit word, big-endian
// WRITE  | single-cycle memory write strobe
// CHK    | waiting for checksum byte (checksum build only)
// DONE   | image loaded, core released
// ERR    | image rejected, core held
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    WORD,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t LAST_STATE = CHK;
`else
  localparam state_t LAST_STATE = DONE;
`endif

  state_t      state, next_state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [15:0] len_in;
  logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  chk;
`endif

  assign len_in = {len_hi, byte_data};
  assign xfer   = byte_valid & byte_ready;

  always_comb begin
    byte_ready = 1'b0;
    unique case (state)
      LEN_HI, LEN_LO, WORD: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:                  byte_ready = 1'b1;
`endif
      default:              byte_ready = 1'b0;
    endcase
  end

  assign mem_we   = (state == WRITE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign cpu_hold = (state != DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= LEN_HI;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      LEN_HI: if (xfer) next_state = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          // An empty image still passes through CHK so the source can send its 00 checksum
          if (len_in == 16'd0)       next_state = LAST_STATE;
          else if (len_in > MAX_N)   next_state = ERR;
          else                       next_state = WORD;
        end
      end
      WORD:  if (xfer && byte_cnt == 2'd3) next_state = WRITE;
      WRITE: next_state = (word_idx + 16'd1 == len) ? LAST_STATE : WORD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:   if (xfer) next_state = (byte_data == chk) ? DONE : ERR;
`endif
      DONE, ERR: if (start) next_state = LEN_HI;
      default:   next_state = LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_hi    <= 8'h00;
      len       <= 16'h0000;
      word_idx  <= 16'h0000;
      byte_cnt  <= 2'd0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk       <= 8'h00;
`endif
    end else begin
      unique case (state)
        LEN_HI: if (xfer) len_hi <= byte_data;
        LEN_LO: if (xfer) len <= len_in;
        WORD: begin
          if (xfer) begin
            mem_wdata <= {mem_wdata[23:0], byte_data};
            byte_cnt  <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk       <= chk ^ byte_data;
`endif
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          mem_addr <= mem_addr + 32'd4;
        end
        DONE, ERR: begin
          if (start) begin
            len_hi   <= 8'h00;
            len      <= 16'h0000;
            word_idx <= 16'h0000;
            byte_cnt <= 2'd0;
            mem_addr <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk      <= 8'h00;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader; covers the checksum build when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stim[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  // Must be called just after a rising edge so the byte transfers exactly once.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++; errors++;
      $display("FAIL send_byte: byte_ready never rose for byte %02h", b);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_stim(input bit gaps);
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i]);
      if (gaps && i + 1 < stim.size()) begin
        if (mem_we) begin
          checks++;
          if (byte_ready !== 1'b0) begin
            errors++; $display("FAIL write_ready: byte_ready=%0b want 0", byte_ready);
          end
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!done && !error && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done && !error) begin
      errors++; $display("FAIL wait_end: no done/error within 30 cycles");
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({done, error, cpu_hold, byte_ready} !== 4'b0011) begin
      errors++; $display("FAIL start: done/error/hold/ready=%04b want 0011", {done, error, cpu_hold, byte_ready});
    end
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; byte_valid = 1'b1; byte_data = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({byte_ready, cpu_hold, mem_we, done, error} !== 5'b11000) begin
      errors++; $display("FAIL reset_flags: ready/hold/we/done/err=%05b want 11000", {byte_ready, cpu_hold, mem_we, done, error});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus: addr=%08h data=%08h want 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b1; byte_valid = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_two_words(input string name);
    checks++;
    if (wr_addr.size() !== 2) begin
      errors++; $display("FAIL %s_count: writes=%0d want 2", name, wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h2408_0005) begin
        errors++; $display("FAIL %s_w0: addr=%08h data=%08h want 00000000/24080005", name, wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h8C09_0000) begin
        errors++; $display("FAIL %s_w1: addr=%08h data=%08h want 00000004/8c090000", name, wr_addr[1], wr_data[1]);
      end
    end
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++; $display("FAIL %s_end: done/err/hold=%03b want 100", name, {done, error, cpu_hold});
    end
  endtask

  task automatic test_basic();
    stim = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'hAC);
`endif
    send_stim(1'b0);
    wait_end();
    check_two_words("basic");
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({done, cpu_hold, byte_ready} !== 3'b100) begin
      errors++; $display("FAIL done_hold: done/hold/ready=%03b want 100", {done, cpu_hold, byte_ready});
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    stim = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'hAC);
`endif
    send_stim(1'b1);
    wait_end();
    check_two_words("gaps");
  endtask

  task automatic test_oversize();
    pulse_start();
    stim = '{8'h00, 8'h41};
    send_stim(1'b0);
    checks++;
    if ({error, cpu_hold, done, byte_ready} !== 4'b1100) begin
      errors++; $display("FAIL oversize: err/hold/done/ready=%04b want 1100", {error, cpu_hold, done, byte_ready});
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (wr_addr.size() !== 0 || error !== 1'b1) begin
      errors++; $display("FAIL oversize_hold: writes=%0d error=%0b want 0/1", wr_addr.size(), error);
    end
    pulse_start();
    stim = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'h22);
`endif
    send_stim(1'b0);
    wait_end();
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEAD_BEEF || done !== 1'b1) begin
      errors++; $display("FAIL rearm_load: writes=%0d addr=%08h data=%08h done=%0b want 1/0/deadbeef/1",
                         wr_addr.size(), wr_addr[0], wr_data[0], done);
    end
  endtask

  task automatic test_zero_len();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if ({done, byte_ready} !== 2'b01) begin
      errors++; $display("FAIL zero_chk_wait: done/ready=%02b want 01", {done, byte_ready});
    end
    send_byte(8'h00);
`endif
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++; $display("FAIL zero_len: done/err/hold=%03b want 100", {done, error, cpu_hold});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_addr.size() !== 0) begin
      errors++; $display("FAIL zero_writes: writes=%0d want 0", wr_addr.size());
    end
  endtask

  task automatic test_reset_midword();
    pulse_start();
    stim = '{8'h00, 8'h02, 8'h11, 8'h22};
    send_stim(1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if ({mem_we, cpu_hold, done, error, byte_ready} !== 5'b01001 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL midword_reset: we/hold/done/err/ready=%05b addr=%08h data=%08h want 01001/0/0",
                         {mem_we, cpu_hold, done, error, byte_ready}, mem_addr, mem_wdata);
    end
    stim = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim.push_back(8'h04);
`endif
    send_stim(1'b0);
    wait_end();
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hA1B2_C3D4 || done !== 1'b1) begin
      errors++; $display("FAIL midword_reload: writes=%0d addr=%08h data=%08h done=%0b want 1/0/a1b2c3d4/1",
                         wr_addr.size(), wr_addr[0], wr_data[0], done);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_stim(1'b0);
    wait_end();
    checks++;
    if ({done, error} !== 2'b10 || wr_addr.size() !== 1) begin
      errors++; $display("FAIL chk_good: done/err=%02b writes=%0d want 10/1", {done, error}, wr_addr.size());
    end
    pulse_start();
    stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_stim(1'b0);
    wait_end();
    checks++;
    if ({done, error, cpu_hold} !== 3'b011 || wr_addr.size() !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h1122_3344) begin
      errors++; $display("FAIL chk_bad: done/err/hold=%03b writes=%0d data=%08h want 011/1/11223344",
                         {done, error, cpu_hold}, wr_addr.size(), wr_data[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_oversize();
    test_zero_len();
    test_reset_midword();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction-memory interface: receives a program as a byte stream, packs it into 32-bit words and writes them into instruction memory at byte addresses matching the fetch stride (PC + 4).
- Holds the core in reset (cpu_hold) until the image is fully written.
- Sits between a byte source (UART receiver or bench) and the instruction memory write port; the core's fetch path remains the reader.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first program word.
- MAX_WORDS, 64, instruction-memory capacity in words; larger images are rejected.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse; re-arms the loader from DONE or ERR
- byte_valid  input  1  source has a byte on byte_data
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle (transfer = valid & ready)
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  32  byte address of the word being written
- mem_wdata  output  32  word being written
- cpu_hold  output  1  keep the core's PC/regs in reset while high
- done  output  1  image loaded successfully (level)
- error  output  1  image rejected (level)

Behaviour:
- Reset (reset==0 at a clock edge): state=LEN_HI; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, word and byte counters=0. Reset wins over every other input, including mid-word and mid-write.
- Stream format: 2-byte word count N (big-endian), then N words of 4 bytes each, big-endian (first byte goes to bits [31:24]).
- byte_ready=1 only in LEN_HI, LEN_LO, WORD (and CHK when enabled); 0 in WRITE, DONE, ERR.
- LEN_HI: on transfer, latch N[15:8] -> LEN_LO.
- LEN_LO: on transfer, latch N[7:0] and decide:
  - N==0 -> DONE.
  - N>MAX_WORDS -> ERR.
  - otherwise -> WORD.
- WORD: on each transfer, shift the byte into the assembly register and increment the byte counter (0..3). On the transfer with byte counter==3 -> WRITE; mem_wdata holds the assembled word from the next cycle.
- WRITE: exactly one cycle with mem_we=1, mem_addr=BASE_ADDR+4*word_idx (32-bit wrap), mem_wdata stable. Then word_idx increments. If word_idx+1==N -> DONE (or CHK), else -> WORD.
- Latency: mem_we rises the cycle after the 4th byte of a word transfers. Maximum throughput is 4 bytes per 5 cycles.
- DONE: done=1, cpu_hold=0 starting the cycle after entry.
- ERR: error=1, cpu_hold=1.
- Both DONE and ERR hold until start or reset. A start pulse clears done/error, sets cpu_hold=1, zeroes the counters -> LEN_HI.
- start in any other state is ignored.
- mem_we=0 in every state except WRITE. mem_addr/mem_wdata may change only when mem_we=0.
- byte_valid with byte_ready=0: the byte is not consumed and the source must hold it (no drop).

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all payload bytes (not the length bytes).
  - After the last WRITE the loader enters CHK and accepts one more byte.
  - Byte equal to the running XOR -> DONE; otherwise -> ERR.
  - Words already written are not rolled back.
  - For N==0 the expected checksum is 8'h00 and CHK still occurs.
- Not defined: no CHK state; the last WRITE goes directly to DONE.

Test Plan:
- Reset with valid=1 streaming -> byte_ready=1, cpu_hold=1, mem_we=0, done=error=0; release, send 00 02 | 24 08 00 05 | 8C 09 00 00 -> two single-cycle strobes: addr 0x0 data 0x24080005, addr 0x4 data 0x8C090000; then done=1, cpu_hold=0.
- Source with gaps (valid toggling every other cycle) plus a byte offered during WRITE -> byte held and accepted in the next WORD cycle; words and addresses identical to the gapless case.
- Length 00 41 (65 > MAX_WORDS=64) -> error=1, cpu_hold=1, no mem_we ever; start pulse -> LEN_HI, error=0; valid 1-word image then loads at addr 0x0.
- Length 00 00 -> done=1 the cycle after the second byte (checksum build: after accepting 8'h00), zero writes.
- reset asserted after the 2nd byte of word 1 -> all outputs at reset values next cycle; a fresh full image loads from addr BASE_ADDR with no stale bytes.
- IMEM_LOADER_CHECKSUM_EN with 1 word 11 22 33 44: trailing byte 0x44 (XOR of 0x11, 0x22, 0x33, 0x44) -> done; trailing byte 0x45 -> error=1, word still written at 0x0.
